i2c_top: RTL and testbench

// Self-contained I2C loopback subsystem: a single-byte I2C master plus an internal 128-byte memory slave.
// The two share one on-chip open-drain SCL/SDA pair.
// - A host issues a write (store din at addr) or a read (fetch the byte at addr) with a one-cycle newd strobe.
// - The block runs the full serial frame and reports completion with done.
// - Used as a protocol demonstrator and as a bus-model block in SoC test fixtures.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_mem_slave.sv | 103 ++++++++++
 rtl/i2c_top.sv | 128 ++++++++++++
 tb/tb_i2c_top.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C loopback subsystem: FSM state sets,
// quarter-phase encoding of a bit slot, and the fixed frame length.
package i2c_pkg;

  typedef enum logic [2:0] {
    M_IDLE, M_START, M_ADDR, M_ACK1, M_DATA, M_ACK2, M_STOP, M_DONE
  } mstate_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_WDATA, S_ACK_W, S_RDATA, S_MACK, S_WAIT_STOP
  } sstate_t;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_t;

  // START + 8 address/op bits + ACK + 8 data bits + ACK + STOP
  localparam int FRAME_BITS = 20;

endpackage

// File: rtl/i2c_mem_slave.sv
// I2C memory slave: 128x8 storage behind a bus-edge-driven FSM. Samples on
// SCL rise, changes its SDA pull on SCL fall, detects START/STOP on SDA edges.
module i2c_mem_slave import i2c_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_in,
  output logic sda_pull
);

  sstate_t    state, state_nx;
  logic       scl_d, sda_d;
  logic       rise, fall, start_det, stop_det;
  logic [7:0] mem [128];
  logic [7:0] sr;
  logic [6:0] addr_r;
  logic       rw;
  logic [2:0] cnt;

  assign rise      = scl & ~scl_d;
  assign fall      = ~scl & scl_d;
  assign start_det = scl & scl_d & sda_d & ~sda_in;
  assign stop_det  = scl & scl_d & ~sda_d & sda_in;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start_det) begin
      state_nx = S_ADDR;
    end else if (stop_det) begin
      state_nx = S_IDLE;
    end else if (rise) begin
      case (state)
        S_ADDR:  if (cnt == 3'd7) state_nx = S_ACK_A;
        S_ACK_A: state_nx = rw ? S_RDATA : S_WDATA;
        S_WDATA: if (cnt == 3'd7) state_nx = S_ACK_W;
        S_ACK_W: state_nx = S_WAIT_STOP;
        S_RDATA: if (cnt == 3'd7) state_nx = S_MACK;
        S_MACK:  state_nx = S_WAIT_STOP;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      sda_pull <= 1'b0;
      sr       <= '0;
      addr_r   <= '0;
      rw       <= 1'b0;
      cnt      <= '0;
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
    end else begin
      scl_d <= scl;
      sda_d <= sda_in;
      if (start_det) begin
        cnt      <= '0;
        sda_pull <= 1'b0;
      end else if (stop_det) begin
        sda_pull <= 1'b0;
      end else begin
        if (rise) begin
          case (state)
            S_ADDR: begin
              sr  <= {sr[6:0], sda_in};
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                addr_r <= sr[6:0];
                rw     <= sda_in;
              end
            end
            S_ACK_A: if (rw) sr <= mem[addr_r];
            S_WDATA: begin
              sr  <= {sr[6:0], sda_in};
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) mem[addr_r] <= {sr[6:0], sda_in};
            end
            S_RDATA: cnt <= cnt + 3'd1;
            default: ;
          endcase
        end
        // The pull set on a fall holds through the next bit's high phase
        if (fall) begin
          case (state)
            S_ACK_A, S_ACK_W: sda_pull <= 1'b1;
            S_RDATA: begin
              sda_pull <= ~sr[7];
              sr       <= {sr[6:0], 1'b0};
            end
            default: sda_pull <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/i2c_top.sv
// Single-byte I2C master looped back onto an internal memory slave over a
// wired-AND SCL/SDA pair; one host request runs one complete 20-slot frame.
module i2c_top import i2c_pkg::*; #(
  parameter int CLKS_PER_BIT = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newd,
  input  logic       op,
  input  logic [6:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       ack_err,
  output logic       done
);

  localparam int Q  = CLKS_PER_BIT / 4;
  localparam int QW = (Q > 1) ? $clog2(Q) : 1;

  mstate_t       state, state_nx;
  quarter_t      qtr;
  logic [QW-1:0] qcnt;
  logic [4:0]    slot;
  logic          op_r;
  logic [7:0]    tx, rx, din_r;
  logic          active, quarter_end, slot_end, sample;
  logic          scl, sda, master_pull, slave_pull;

  assign active      = (state != M_IDLE) && (state != M_DONE);
  assign quarter_end = (qcnt == QW'(Q - 1));
  assign slot_end    = quarter_end && (qtr == Q3);
  assign sample      = active && (qtr == Q2) && (qcnt == '0);

  assign busy = active;
  assign done = (state == M_DONE);
  assign scl  = ~(active && ((qtr == Q0) || (qtr == Q3)));
  assign sda  = ~master_pull & ~slave_pull;

  always_ff @(posedge clk) begin
    if (rst) state <= M_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    master_pull = 1'b0;
    case (state)
      M_IDLE:  if (newd) state_nx = M_START;
      M_START: begin
        master_pull = (qtr == Q2) || (qtr == Q3);
        if (slot_end) state_nx = M_ADDR;
      end
      M_ADDR: begin
        master_pull = ~tx[7];
        if (slot_end && slot == 5'd8) state_nx = M_ACK1;
      end
      M_ACK1:  if (slot_end) state_nx = M_DATA;
      M_DATA: begin
        // After an address NACK the master only clocks the slots out
        master_pull = ~op_r & ~ack_err & ~tx[7];
        if (slot_end && slot == 5'd17) state_nx = M_ACK2;
      end
      M_ACK2:  if (slot_end) state_nx = M_STOP;
      M_STOP: begin
        master_pull = (qtr == Q0) || (qtr == Q1);
        if (slot_end && slot == 5'(FRAME_BITS - 1)) state_nx = M_DONE;
      end
      M_DONE:  state_nx = M_IDLE;
      default: state_nx = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qtr     <= Q0;
      qcnt    <= '0;
      slot    <= '0;
      op_r    <= 1'b0;
      tx      <= '0;
      rx      <= '0;
      din_r   <= '0;
      dout    <= '0;
      ack_err <= 1'b0;
    end else begin
      if (state == M_IDLE && newd) begin
        op_r    <= op;
        tx      <= {addr, op};
        din_r   <= din;
        ack_err <= 1'b0;
        qtr     <= Q0;
        qcnt    <= '0;
        slot    <= '0;
      end
      if (active) begin
        if (quarter_end) begin
          qcnt <= '0;
          qtr  <= quarter_t'(qtr + 2'd1);
        end else begin
          qcnt <= qcnt + 1'b1;
        end
        if (slot_end) begin
          slot <= slot + 5'd1;
          if (state == M_ADDR || state == M_DATA) tx <= {tx[6:0], 1'b0};
          if (state == M_ACK1) tx <= din_r;
        end
        if (sample) begin
          case (state)
            M_ACK1:  if (sda) ack_err <= 1'b1;
            M_DATA:  rx <= {rx[6:0], sda};
            M_ACK2:  if (!op_r && sda) ack_err <= 1'b1;
            default: ;
          endcase
        end
      end
      if (state == M_DONE && op_r && !ack_err) dout <= rx;
    end
  end

  i2c_mem_slave u_slave (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda_in   (sda),
    .sda_pull (slave_pull)
  );

endmodule

// File: tb/tb_i2c_top.sv
// Bench for i2c_top: directed and random transactions against a flat memory
// model, plus busy-time newd, held newd and mid-frame reset.
module tb_i2c_top;

  localparam int CPB          = 40;
  localparam int FRAME_CYCLES = 20 * CPB;

  logic       clk = 1'b0;
  logic       rst, newd, op;
  logic [6:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy, ack_err, done;

  int checks    = 0;
  int errors    = 0;
  int done_seen = 0;

  logic [7:0] ref_mem [128];
  logic [7:0] ref_dout;

  i2c_top #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .newd    (newd),
    .op      (op),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .busy    (busy),
    .ack_err (ack_err),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_seen <= done_seen + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
    ref_dout = 8'h00;
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (done !== 1'b1 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check_output(tag, 32'(c < 1000), 1);
  endtask

  // One full host transaction with latency, handshake and result checks
  task automatic apply_stimulus(input logic o, input logic [6:0] a, input logic [7:0] d);
    int cycles = 0;
    @(negedge clk);
    newd = 1'b1; op = o; addr = a; din = d;
    @(negedge clk);
    newd = 1'b0; op = 1'($urandom); addr = 7'($urandom); din = 8'($urandom);
    check_output("busy_rise", busy, 1);
    while (done !== 1'b1 && cycles < 1000) begin
      @(negedge clk);
      cycles++;
    end
    check_output("done_latency", cycles, FRAME_CYCLES);
    check_output("busy_at_done", busy, 0);
    check_output("ack_err", ack_err, 0);
    if (o) ref_dout = ref_mem[a];
    else   ref_mem[a] = d;
    @(negedge clk);
    check_output("done_width", done, 0);
    check_output(o ? "dout_read" : "dout_hold", dout, ref_dout);
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_ack_err"}, ack_err, 0);
    check_output({tag, "_dout"}, dout, 0);
    check_output({tag, "_scl"}, dut.scl, 1);
    check_output({tag, "_sda"}, dut.sda, 1);
  endtask

  initial begin
    int d0;
    rst = 1'b1; newd = 1'b0; op = 1'b0; addr = '0; din = '0;
    model_reset();

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    apply_stimulus(1'b0, 7'd2, 8'h55);
    apply_stimulus(1'b0, 7'd3, 8'h99);
    apply_stimulus(1'b1, 7'd2, 8'h00);
    apply_stimulus(1'b1, 7'd3, 8'h00);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    apply_stimulus(1'b1, 7'd127, 8'h00);
    apply_stimulus(1'b0, 7'd0, 8'hFF);
    apply_stimulus(1'b1, 7'd0, 8'h00);

    $display("[TB] newd pulsed while busy");
    d0 = done_seen;
    @(negedge clk);
    newd = 1'b1; op = 1'b0; addr = 7'd10; din = 8'hA5;
    @(negedge clk);
    newd = 1'b0;
    repeat (300) @(negedge clk);
    newd = 1'b1; op = 1'b1; addr = 7'd20; din = 8'h5A;
    @(negedge clk);
    newd = 1'b0;
    wait_done("busy_newd_done");
    ref_mem[10] = 8'hA5;
    repeat (2 * FRAME_CYCLES) @(negedge clk);
    check_output("busy_newd_done_count", done_seen - d0, 1);
    check_output("busy_newd_idle", busy, 0);
    apply_stimulus(1'b1, 7'd10, 8'h00);
    apply_stimulus(1'b1, 7'd20, 8'h00);

    $display("[TB] newd held across done");
    d0 = done_seen;
    @(negedge clk);
    newd = 1'b1; op = 1'b0; addr = 7'd40; din = 8'h3C;
    wait_done("held_first_done");
    @(negedge clk);
    check_output("held_idle_gap", busy, 0);
    @(negedge clk);
    check_output("held_retrigger", busy, 1);
    newd = 1'b0;
    wait_done("held_second_done");
    @(negedge clk);
    check_output("held_done_count", done_seen - d0, 2);
    ref_mem[40] = 8'h3C;
    apply_stimulus(1'b1, 7'd40, 8'h00);

    $display("[TB] random transactions");
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 7'(60 + $urandom_range(0, 7)), 8'($urandom));
    end

    $display("[TB] reset during write data phase");
    @(negedge clk);
    newd = 1'b1; op = 1'b0; addr = 7'd5; din = 8'hC3;
    @(negedge clk);
    newd = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    check_output("mid_frame_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid_reset");
    rst = 1'b0;
    model_reset();
    apply_stimulus(1'b1, 7'd5, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
